// File: rtl/tlb_cp0_ctrl.sv
// CP0 TLB-management registers (Index, Random, EntryLo0/1, PageMask, Wired, EntryHi)
// plus the sequencer that hands TLBP/TLBR/TLBWI/TLBWR to the TLB and writes back results.
module tlb_cp0_ctrl #(
    parameter int unsigned TLBEntries = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    output logic        op_ready,
    output logic        op_done,
    output logic [2:0]  tlb_req,
    output logic [4:0]  tlb_index,
    output logic [31:0] tlb_entryhi,
    output logic [31:0] tlb_entrylo0,
    output logic [31:0] tlb_entrylo1,
    input  logic        tlb_done,
    input  logic        tlb_hit,
    input  logic [4:0]  tlb_hit_index,
    input  logic [31:0] tlb_res_entryhi,
    input  logic [31:0] tlb_res_entrylo0,
    input  logic [31:0] tlb_res_entrylo1,
    input  logic        exc_valid,
    input  logic [31:0] exc_vaddr
);
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned LO_W   = 26;
    localparam int unsigned VPN2_W = 19;
    localparam int unsigned ASID_W = 8;

    localparam logic [IDX_W-1:0] RAND_MAX   = IDX_W'(TLBEntries - 1);
    localparam logic [4:0]       REG_INDEX  = 5'd0;
    localparam logic [4:0]       REG_RANDOM = 5'd1;
    localparam logic [4:0]       REG_LO0    = 5'd2;
    localparam logic [4:0]       REG_LO1    = 5'd3;
    localparam logic [4:0]       REG_WIRED  = 5'd6;
    localparam logic [4:0]       REG_HI     = 5'd10;
    localparam logic [1:0]       OP_TLBP    = 2'd0;
    localparam logic [1:0]       OP_TLBR    = 2'd1;
    localparam logic [1:0]       OP_TLBWR   = 2'd3;
    localparam logic [2:0]       REQ_NONE   = 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              state, state_next;
    logic                accept, done_evt;
    logic [1:0]          op_q;
    logic                index_p;
    logic [IDX_W-1:0]    index_idx, random, random_next, wired;
    logic [LO_W-1:0]     lo0, lo1;
    logic [VPN2_W-1:0]   vpn2;
    logic [ASID_W-1:0]   asid;
    logic                wr_index, wr_lo0, wr_lo1, wr_wired, wr_hi;
    logic                wb_tlbp, wb_tlbr;
    logic                unused_bits;

    assign wr_index = cp0_we && (cp0_waddr == REG_INDEX);
    assign wr_lo0   = cp0_we && (cp0_waddr == REG_LO0);
    assign wr_lo1   = cp0_we && (cp0_waddr == REG_LO1);
    assign wr_wired = cp0_we && (cp0_waddr == REG_WIRED);
    assign wr_hi    = cp0_we && (cp0_waddr == REG_HI);
    assign wb_tlbp  = done_evt && (op_q == OP_TLBP);
    assign wb_tlbr  = done_evt && (op_q == OP_TLBR);

    // Bits that CP0 never stores (page offset, reserved fields)
    assign unused_bits = ^{exc_vaddr[12:0], tlb_res_entryhi[12:8],
                           tlb_res_entrylo0[31:26], tlb_res_entrylo1[31:26]};

    // Sequencer state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done_evt   = 1'b0;
        case (state)
            S_IDLE:  if (op_valid) begin
                         accept     = 1'b1;
                         state_next = S_ISSUE;
                     end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (tlb_done) begin
                         done_evt   = 1'b1;
                         state_next = S_IDLE;
                     end
            default: state_next = S_IDLE;
        endcase
    end

    // Random counts down through the non-wired entries; a Wired write restarts it at the top
    always_comb begin
        random_next = random - IDX_W'(1);
        if (wr_wired || (wired >= RAND_MAX) || (random == wired) || (random == '0))
            random_next = RAND_MAX;
    end

    // Sequencer outputs and operation snapshot
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q      <= OP_TLBP;
            tlb_index <= '0;
            tlb_req   <= REQ_NONE;
            op_done   <= 1'b0;
            op_ready  <= 1'b1;
        end else begin
            op_done  <= done_evt;
            op_ready <= (state_next == S_IDLE);
            if (accept) begin
                op_q      <= op_code;
                tlb_index <= (op_code == OP_TLBWR) ? random : index_idx;
                tlb_req   <= 3'(op_code) + 3'd1;
            end else if (done_evt) begin
                tlb_req   <= REQ_NONE;
            end
        end
    end

    // CP0 registers; TLB writeback beats exception capture beats MTC0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            index_p   <= 1'b0;
            index_idx <= '0;
            random    <= RAND_MAX;
            wired     <= '0;
            lo0       <= '0;
            lo1       <= '0;
            vpn2      <= '0;
            asid      <= '0;
        end else begin
            random <= random_next;
            if (wr_wired) wired <= cp0_wdata[IDX_W-1:0];

            if (wb_tlbp) begin
                index_p   <= ~tlb_hit;
                index_idx <= tlb_hit ? tlb_hit_index : '0;
            end else if (wr_index) begin
                index_idx <= cp0_wdata[IDX_W-1:0];
            end

            if (wb_tlbr) begin
                vpn2 <= tlb_res_entryhi[31:13];
                asid <= tlb_res_entryhi[ASID_W-1:0];
                lo0  <= tlb_res_entrylo0[LO_W-1:0];
                lo1  <= tlb_res_entrylo1[LO_W-1:0];
            end else begin
                if (exc_valid) begin
                    vpn2 <= exc_vaddr[31:13];
                end else if (wr_hi) begin
                    vpn2 <= cp0_wdata[31:13];
                    asid <= cp0_wdata[ASID_W-1:0];
                end
                if (wr_lo0) lo0 <= cp0_wdata[LO_W-1:0];
                if (wr_lo1) lo1 <= cp0_wdata[LO_W-1:0];
            end
        end
    end

    assign tlb_entryhi  = {vpn2, 5'b0, asid};
    assign tlb_entrylo0 = {6'b0, lo0};
    assign tlb_entrylo1 = {6'b0, lo1};

    // MFC0 read mux; PageMask and unimplemented registers read zero
    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            REG_INDEX:  cp0_rdata = {index_p, 26'b0, index_idx};
            REG_RANDOM: cp0_rdata = {27'b0, random};
            REG_LO0:    cp0_rdata = tlb_entrylo0;
            REG_LO1:    cp0_rdata = tlb_entrylo1;
            REG_WIRED:  cp0_rdata = {27'b0, wired};
            REG_HI:     cp0_rdata = tlb_entryhi;
            default:    cp0_rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_tlb_cp0_ctrl.sv
// Self-checking bench for tlb_cp0_ctrl: directed scenarios then randomized traffic,
// all compared against a register-image reference model.
module tb_tlb_cp0_ctrl;
    localparam int N = 32;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cp0_we;
    logic [4:0]  cp0_waddr, cp0_raddr;
    logic [31:0] cp0_wdata, cp0_rdata;
    logic        op_valid, op_ready, op_done;
    logic [1:0]  op_code;
    logic [2:0]  tlb_req;
    logic [4:0]  tlb_index, tlb_hit_index;
    logic [31:0] tlb_entryhi, tlb_entrylo0, tlb_entrylo1;
    logic        tlb_done, tlb_hit, exc_valid;
    logic [31:0] tlb_res_entryhi, tlb_res_entrylo0, tlb_res_entrylo1, exc_vaddr;

    tlb_cp0_ctrl #(.TLBEntries(N)) dut (
        .clk(clk), .resetn(resetn),
        .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
        .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
        .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready), .op_done(op_done),
        .tlb_req(tlb_req), .tlb_index(tlb_index), .tlb_entryhi(tlb_entryhi),
        .tlb_entrylo0(tlb_entrylo0), .tlb_entrylo1(tlb_entrylo1),
        .tlb_done(tlb_done), .tlb_hit(tlb_hit), .tlb_hit_index(tlb_hit_index),
        .tlb_res_entryhi(tlb_res_entryhi), .tlb_res_entrylo0(tlb_res_entrylo0),
        .tlb_res_entrylo1(tlb_res_entrylo1),
        .exc_valid(exc_valid), .exc_vaddr(exc_vaddr)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    // Reference model: architectural register images and operation progress
    logic [31:0] m_index, m_ehi, m_lo0, m_lo1;
    int          m_random, m_wired;
    int          m_phase;            // 0 idle, 1 issuing, 2 waiting for TLB
    logic [1:0]  m_op;
    logic [4:0]  m_snap;
    logic        m_done;
    logic [2:0]  m_req;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_index = 0; m_ehi = 0; m_lo0 = 0; m_lo1 = 0;
        m_random = N - 1; m_wired = 0;
        m_phase = 0; m_op = 0; m_snap = 0; m_done = 0; m_req = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] r);
        case (r)
            5'd0:    return m_index;
            5'd1:    return 32'(m_random);
            5'd2:    return m_lo0;
            5'd3:    return m_lo1;
            5'd6:    return 32'(m_wired);
            5'd10:   return m_ehi;
            default: return 32'h0;
        endcase
    endfunction

    // Apply one rising edge to the model using the inputs held across that edge
    task automatic model_edge();
        logic [31:0] n_index, n_ehi, n_lo0, n_lo1;
        int          n_random, n_wired;
        bit          wb;
        wb = (m_phase == 2) && tlb_done;
        n_index = m_index; n_ehi = m_ehi; n_lo0 = m_lo0; n_lo1 = m_lo1; n_wired = m_wired;

        if (cp0_we && cp0_waddr == 5'd6)          n_random = N - 1;
        else if (m_wired >= N - 1)                n_random = N - 1;
        else if (m_random == m_wired || m_random == 0) n_random = N - 1;
        else                                      n_random = m_random - 1;

        if (cp0_we && cp0_waddr == 5'd6) n_wired = int'(cp0_wdata & 32'h1F);

        if (wb && m_op == 2'd0)
            n_index = tlb_hit ? {27'b0, tlb_hit_index} : 32'h8000_0000;
        else if (cp0_we && cp0_waddr == 5'd0)
            n_index = (m_index & 32'h8000_0000) | (cp0_wdata & 32'h1F);

        if (wb && m_op == 2'd1) begin
            n_ehi = tlb_res_entryhi & 32'hFFFF_E0FF;
            n_lo0 = tlb_res_entrylo0 & 32'h03FF_FFFF;
            n_lo1 = tlb_res_entrylo1 & 32'h03FF_FFFF;
        end else begin
            if (exc_valid)                          n_ehi = (exc_vaddr & 32'hFFFF_E000) | (m_ehi & 32'hFF);
            else if (cp0_we && cp0_waddr == 5'd10)  n_ehi = cp0_wdata & 32'hFFFF_E0FF;
            if (cp0_we && cp0_waddr == 5'd2) n_lo0 = cp0_wdata & 32'h03FF_FFFF;
            if (cp0_we && cp0_waddr == 5'd3) n_lo1 = cp0_wdata & 32'h03FF_FFFF;
        end

        m_done = wb;
        if (m_phase == 0 && op_valid) begin
            m_phase = 1;
            m_op    = op_code;
            m_snap  = (op_code == 2'd3) ? 5'(m_random) : m_index[4:0];
            m_req   = 3'(op_code) + 3'd1;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (wb) begin
            m_phase = 0;
            m_req   = 0;
        end

        m_index = n_index; m_ehi = n_ehi; m_lo0 = n_lo0; m_lo1 = n_lo1;
        m_random = n_random; m_wired = n_wired;
    endtask

    task automatic check_all();
        logic [4:0] regs [8];
        regs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd10, 5'($urandom_range(11, 31))};
        for (int i = 0; i < 8; i++) begin
            cp0_raddr = regs[i];
            #1;
            chk($sformatf("rd_reg%0d", regs[i]), cp0_rdata, model_read(regs[i]));
        end
        chk("op_ready",  32'(op_ready),  32'(m_phase == 0));
        chk("op_done",   32'(op_done),   32'(m_done));
        chk("tlb_req",   32'(tlb_req),   32'(m_req));
        chk("tlb_index", 32'(tlb_index), 32'(m_snap));
        chk("tlb_entryhi",  tlb_entryhi,  m_ehi);
        chk("tlb_entrylo0", tlb_entrylo0, m_lo0);
        chk("tlb_entrylo1", tlb_entrylo1, m_lo1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (resetn) model_edge(); else model_reset();
        #1;
        check_all();
        if (op_done === 1'b1) done_cnt++;
    endtask

    task automatic quiet_inputs();
        cp0_we = 0; cp0_waddr = 0; cp0_wdata = 0; op_valid = 0; op_code = 0;
        tlb_done = 0; exc_valid = 0; exc_vaddr = 0;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        cp0_we = 1; cp0_waddr = r; cp0_wdata = d;
        tick();
        cp0_we = 0;
    endtask

    task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
        cp0_raddr = r;
        #1;
        v = cp0_rdata;
    endtask

    // Issue one TLB op; the bench plays the TLB, answering after extra_wait cycles in WAIT
    task automatic run_op(input logic [1:0] code, input int extra_wait, input int exp_idx);
        int guard;
        op_valid = 1; op_code = code;
        tick();
        op_valid = 0;
        guard = 0;
        while (m_phase != 2 && guard < 8) begin
            tick();
            guard++;
        end
        for (int i = 0; i < extra_wait; i++) begin
            tick();
            if (exp_idx >= 0) chk("held_tlb_index", 32'(tlb_index), 32'(exp_idx));
        end
        tlb_done = 1;
        tick();
        tlb_done = 0;
        chk("op_done_pulse", 32'(op_done), 32'd1);
        chk("op_ready_back", 32'(op_ready), 32'd1);
        if (exp_idx >= 0) chk("final_tlb_index", 32'(tlb_index), 32'(exp_idx));
        tick();
        chk("op_done_single", 32'(op_done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        int guard;
        quiet_inputs();
        cp0_raddr = 0; tlb_hit = 0; tlb_hit_index = 0;
        tlb_res_entryhi = 0; tlb_res_entrylo0 = 0; tlb_res_entrylo1 = 0;
        resetn = 0;
        model_reset();
        tick();
        tick();
        read_reg(5'd1, v);
        chk("reset_random", v, 32'd31);
        chk("reset_op_ready", 32'(op_ready), 32'd1);
        chk("reset_tlb_req", 32'(tlb_req), 32'd0);
        resetn = 1;

        // Random free-runs 31..0 and wraps
        for (int k = 1; k <= 40; k++) begin
            tick();
            read_reg(5'd1, v);
            chk("random_seq", v, 32'((31 - k) & 31));
        end

        // Wired=8: restart at 31, count down to 8, wrap
        mtc0(5'd6, 32'd8);
        read_reg(5'd1, v);
        chk("wired_restart", v, 32'd31);
        for (int j = 1; j <= 24; j++) begin
            tick();
            read_reg(5'd1, v);
            chk("wired_seq", v, (j <= 23) ? 32'(31 - j) : 32'd31);
        end

        // TLBP hit then miss
        mtc0(5'd10, 32'h0040_2005);
        read_reg(5'd10, v);
        chk("entryhi_write", v, 32'h0040_2005);
        tlb_hit = 1; tlb_hit_index = 5'd7;
        run_op(2'd0, 1, -1);
        read_reg(5'd0, v);
        chk("tlbp_hit_index", v, 32'h0000_0007);
        tlb_hit = 0; tlb_hit_index = 5'd19;
        run_op(2'd0, 0, -1);
        read_reg(5'd0, v);
        chk("tlbp_miss_index", v, 32'h8000_0000);

        // TLBR with Index=3, result masked to 26 bits
        mtc0(5'd0, 32'hFFFF_FFE3);
        read_reg(5'd0, v);
        chk("index_p_readonly", v, 32'h8000_0003);
        tlb_res_entryhi = 32'h0; tlb_res_entrylo0 = 32'hFFFF_FFFF; tlb_res_entrylo1 = 32'h1234_5678;
        done_cnt = 0;
        run_op(2'd1, 3, 3);
        read_reg(5'd2, v);
        chk("tlbr_lo0", v, 32'h03FF_FFFF);
        read_reg(5'd3, v);
        chk("tlbr_lo1", v, 32'h0234_5678);
        chk("tlbr_done_count", 32'(done_cnt), 32'd1);

        // TLBWR snapshots Random=12 while Random keeps moving
        guard = 0;
        while (m_random != 12 && guard < 64) begin
            tick();
            guard++;
        end
        chk("reach_random12", 32'(m_random), 32'd12);
        run_op(2'd3, 10, 12);

        // TLBWI uses Index
        run_op(2'd2, 2, 3);

        // Exception capture beats a same-cycle MTC0 EntryHi
        exc_valid = 1; exc_vaddr = 32'h1234_5678;
        mtc0(5'd10, 32'h0);
        exc_valid = 0;
        read_reg(5'd10, v);
        chk("exc_entryhi", v, 32'h1234_4000);

        // Reset during WAIT: no writeback, no op_done
        tlb_res_entrylo0 = 32'h0000_ABCD;
        op_valid = 1; op_code = 2'd1;
        tick();
        op_valid = 0;
        tick();
        tlb_done = 1;
        resetn = 0;
        model_reset();
        tick();
        tlb_done = 0;
        chk("rst_mid_lo0", tlb_entrylo0, 32'h0);
        chk("rst_mid_req", 32'(tlb_req), 32'd0);
        resetn = 1;
        tick();
        chk("rst_mid_no_done", 32'(op_done), 32'd0);
        chk("rst_mid_ready", 32'(op_ready), 32'd1);

        // Randomized traffic, including tlb_done/op_valid at the wrong times
        mtc0(5'd6, 32'd0);
        for (int c = 0; c < 400; c++) begin
            logic [4:0] waddr_pick [8];
            waddr_pick = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd10, 5'($urandom_range(0, 31))};
            cp0_we           = ($urandom_range(0, 3) == 0);
            cp0_waddr        = waddr_pick[$urandom_range(0, 7)];
            cp0_wdata        = $urandom;
            if (cp0_waddr == 5'd6 && $urandom_range(0, 3) != 0) cp0_wdata = 32'($urandom_range(0, 20));
            op_valid         = ($urandom_range(0, 2) == 0);
            op_code          = 2'($urandom_range(0, 3));
            tlb_done         = ($urandom_range(0, 2) == 0);
            tlb_hit          = 1'($urandom_range(0, 1));
            tlb_hit_index    = 5'($urandom_range(0, 31));
            tlb_res_entryhi  = $urandom;
            tlb_res_entrylo0 = $urandom;
            tlb_res_entrylo1 = $urandom;
            exc_valid        = ($urandom_range(0, 7) == 0);
            exc_vaddr        = $urandom;
            tick();
        end
        quiet_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tlb_cp0_ctrl.md
TLB_CP0_CTRL -- requirements
Module: tlb_cp0_ctrl

Interface
REQ-001 SHALL have parameter TLBEntries, default 32, meaning number of TLB entries (power of 2, ≤32).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cp0_we  input  1  MTC0 write strobe.
REQ-005 SHALL have port cp0_waddr  input  5  CP0 register number for write.
REQ-006 SHALL have port cp0_wdata  input  32  MTC0 data.
REQ-007 SHALL have port cp0_raddr  input  5  CP0 register number for MFC0.
REQ-008 SHALL have port cp0_rdata  output  32  combinational MFC0 read data.
REQ-009 SHALL have port op_valid  input  1  pipeline TLB instruction request.
REQ-010 SHALL have port op_code  input  2  0=TLBP, 1=TLBR, 2=TLBWI, 3=TLBWR.
REQ-011 SHALL have port op_ready  output  1  high only in IDLE.
REQ-012 SHALL have port op_done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port tlb_req  output  3  0=NONE, 1=TLBP, 2=TLBR, 3=TLBWI, 4=TLBWR to TLB.
REQ-014 SHALL have ports tlb_index(5), tlb_entryhi(32), tlb_entrylo0(32), tlb_entrylo1(32)  output  register images driven to TLB.
REQ-015 SHALL have port tlb_done  input  1  TLB operation complete.
REQ-016 SHALL have ports tlb_hit(1), tlb_hit_index(5), tlb_res_entryhi(32), tlb_res_entrylo0(32), tlb_res_entrylo1(32)  input  TLB results.
REQ-017 SHALL have ports exc_valid(1), exc_vaddr(32)  input  TLB-refill/invalid/modified exception capture.

Function
REQ-018 Registers: Index(0) {P[31], idx[4:0]}; Random(1) [4:0]; EntryLo0(2)/EntryLo1(3) [25:0]; PageMask(5) always 0; Wired(6) [4:0]; EntryHi(10) {VPN2[31:13], ASID[7:0]}; all unlisted bits/registers read 0.
REQ-019 MTC0 writable bits: Index[4:0] only (P read-only), EntryLo[25:0], Wired[4:0], EntryHi[31:13]/[7:0]; writes to Random/PageMask ignored.
REQ-020 Writing Wired SHALL set Random to TLBEntries-1 on the same edge.
REQ-021 Random SHALL decrement each cycle; when Random==Wired or Random==0 it SHALL wrap to TLBEntries-1 next cycle; Wired≥TLBEntries-1 holds Random at TLBEntries-1.
REQ-022 FSM states IDLE, ISSUE, WAIT; IDLE->ISSUE when op_valid; ISSUE->WAIT after one cycle; WAIT->IDLE on tlb_done.
REQ-023 On acceptance SHALL latch op_code and snapshot tlb_index = Index.idx (TLBWI/TLBR/TLBP) or Random (TLBWR); snapshot held until IDLE.
REQ-024 tlb_req SHALL be non-NONE only in ISSUE and WAIT; tlb_entryhi/lo0/lo1 reflect live registers.
REQ-025 On tlb_done: TLBP writes Index = {~tlb_hit, 26'b0, hit?tlb_hit_index:0}; TLBR writes EntryHi, EntryLo0, EntryLo1 from tlb_res_* (masked per REQ-019); TLBWI/TLBWR write nothing.
REQ-026 op_done SHALL pulse exactly on the cycle after the tlb_done edge (FSM back in IDLE); latency accept->op_done ≥3 cycles.
REQ-027 exc_valid SHALL load EntryHi.VPN2 = exc_vaddr[31:13]; ASID unchanged.
REQ-028 Same-edge write priority per register: TLB writeback > exception capture > MTC0.
REQ-029 tlb_done seen outside WAIT SHALL be ignored; op_valid outside IDLE SHALL be ignored.

Reset
REQ-030 On resetn low, asynchronously: FSM=IDLE, Index=0, Random=TLBEntries-1, Wired=0, EntryHi=EntryLo0=EntryLo1=0, tlb_req=NONE, op_done=0, op_ready=1 after release.
REQ-031 Reset mid-operation SHALL abandon the op with no register writeback and no op_done.

Verification
REQ-032 Reset release, idle 40 cycles, read Random each cycle -> 31,30,...,0,31,... sequence.
REQ-033 MTC0 Wired=8 -> Random=31 next cycle, decrements to 8, then wraps to 31.
REQ-034 EntryHi=0x0040_2005, TLBP, tlb_hit=1 idx=7 -> Index reads 0x0000_0007; repeat with tlb_hit=0 -> 0x8000_0000.
REQ-035 Index=3, TLBR, tlb_res_entrylo0=0xFFFF_FFFF -> EntryLo0 reads 0x03FF_FFFF, tlb_index=3 throughout, one op_done.
REQ-036 TLBWR accepted with Random=12 -> tlb_index=12 held while Random keeps changing until tlb_done.
REQ-037 exc_valid with exc_vaddr=0x1234_5678 and same-cycle MTC0 EntryHi=0 -> EntryHi reads 0x1234_4000.
